// File: rtl/opb_initiator_if.sv
// Bundles the command/response handshake and the shared OPB buses seen by opb_initiator.
// The master modport is the initiator's view; the slave modport is the host/peripheral side.
interface opb_initiator_if #(
  parameter int unsigned NUM_SLAVES = 8
);
  localparam int unsigned DW = 32;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_wr;
  logic [DW-1:0]             cmd_addr;
  logic [DW-1:0]             cmd_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DW-1:0]             rsp_rdata;
  logic                      rsp_err;
  logic [DW-1:0]             opb_addr;
  logic [DW-1:0]             opb_wdata;
  logic [DW*NUM_SLAVES-1:0]  opb_rdata;
  logic [NUM_SLAVES-1:0]     slv_re;
  logic [NUM_SLAVES-1:0]     slv_we;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, opb_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, opb_addr, opb_wdata, slv_re, slv_we
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, opb_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, opb_addr, opb_wdata, slv_re, slv_we
  );
endinterface

// File: rtl/opb_initiator.sv
// Single-beat OPB initiator: decodes a slave index from the command address, pulses one
// RE/WE strobe, captures read data after RD_LAT clocks and returns a valid/ready response.
module opb_initiator #(
  parameter int unsigned NUM_SLAVES = 8,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic           OPB_CLK,
  input  logic           OPB_RST,
  opb_initiator_if.master bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state_q,     state_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic                  wr_q,        wr_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [DW-1:0]         opb_addr_q,  opb_addr_d;
  logic [DW-1:0]         opb_wdata_q, opb_wdata_d;
  logic [NUM_SLAVES-1:0] re_q,        re_d;
  logic [NUM_SLAVES-1:0] we_q,        we_d;

  logic [IDX_W-1:0]      cmd_idx_c;
  logic [DW-1:0]         rd_word_c;

  assign cmd_idx_c = bus.cmd_addr[11:8];

  // Read-data mux by latched index; unselected slaves cannot corrupt the word.
  always_comb begin
    rd_word_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) rd_word_c = bus.opb_rdata[DW*i +: DW];
    end
  end

  // Next-state and next-output logic; strobes default low so they last one cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    opb_addr_d  = opb_addr_q;
    opb_wdata_d = opb_wdata_q;
    re_d        = '0;
    we_d        = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          opb_addr_d  = bus.cmd_addr;
          opb_wdata_d = bus.cmd_wdata;
          wr_d        = bus.cmd_wr;
          idx_d       = cmd_idx_c;
          if (32'(cmd_idx_c) < NUM_SLAVES) begin
            state_d = ST_STROBE;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
              we_d[i] = bus.cmd_wr  && (cmd_idx_c == IDX_W'(i));
              re_d[i] = !bus.cmd_wr && (cmd_idx_c == IDX_W'(i));
            end
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ST_STROBE: begin
        if (wr_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = rd_word_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready is registered, so it rises the cycle after the response is consumed.
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      opb_addr_q  <= '0;
      opb_wdata_q <= '0;
      re_q        <= '0;
      we_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      opb_addr_q  <= opb_addr_d;
      opb_wdata_q <= opb_wdata_d;
      re_q        <= re_d;
      we_q        <= we_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.opb_addr  = opb_addr_q;
  assign bus.opb_wdata = opb_wdata_q;
  assign bus.slv_re    = re_q;
  assign bus.slv_we    = we_q;

endmodule

// File: doc/opb_initiator.md
# opb_initiator

OPB bus initiator that converts single-beat command requests (from the host command decoder) into OPB register accesses on the peripheral slaves. Slaves include GPIO and the other OPB register blocks. The block decodes the slave index from the command address and drives the shared OPB address/write-data buses. It pulses exactly one slave's RE or WE strobe, captures the returned read word after a fixed latency, and presents a response with valid/ready handshake. It is the requester side of the slave register interface used throughout the FPGA.

## Interface
- NUM_SLAVES, 8, number of OPB slaves attached (1..16)
- RD_LAT, 1, clocks from the RE strobe cycle to the cycle in which the slave's OPB_DO holds read data (1..4)
- OPB_CLK  in  1  system clock; all logic rising-edge
- OPB_RST  in  1  reset, asynchronous, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  initiator can accept a command
- CMD_WR  in  1  1 = write, 0 = read
- CMD_ADDR  in  32  [11:8] slave index, [3:0] register offset, other bits passed through
- CMD_WDATA  in  32  write data
- RSP_VALID  out  1  response present
- RSP_READY  in  1  response consumer ready
- RSP_RDATA  out  32  read data (0 for writes and errors)
- RSP_ERR  out  1  slave index >= NUM_SLAVES
- OPB_ADDR  out  32  address bus to all slaves
- OPB_WDATA  out  32  write data bus to all slaves (slave OPB_DI)
- OPB_RDATA  in  32*NUM_SLAVES  slave OPB_DO words; slave i at [32*i+31:32*i]
- SLV_RE  out  NUM_SLAVES  per-slave read strobe
- SLV_WE  out  NUM_SLAVES  per-slave write strobe

## Operation
- States: IDLE, STROBE, WAIT, RESP.
- IDLE: CMD_READY=1. On CMD_VALID&CMD_READY, register CMD_ADDR→OPB_ADDR, CMD_WDATA→OPB_WDATA, CMD_WR, and index=CMD_ADDR[11:8].
  - index < NUM_SLAVES: go to STROBE.
  - Otherwise: go to RESP with RSP_ERR=1, RSP_RDATA=0; no strobe is issued.
- STROBE (exactly one cycle): SLV_WE[index]=1 for a write, or SLV_RE[index]=1 for a read; all other strobe bits 0.
  - Write: next state is RESP with RSP_RDATA=0, RSP_ERR=0.
  - Read: next state is WAIT with counter loaded to RD_LAT-1.
- WAIT: counter decrements each cycle. When the counter is 0, capture OPB_RDATA word [index] into RSP_RDATA and go to RESP. Word selection is a mux by index, not an OR of all slaves.
- RESP: RSP_VALID=1, RSP_RDATA/RSP_ERR stable. On RSP_READY go to IDLE.
- OPB_ADDR/OPB_WDATA hold their value from accept until the next accept. They never change while a strobe is high or while read data is pending.
- CMD_READY=0 in every state except IDLE. No command is accepted in the same cycle a response is consumed; the earliest next accept is the cycle after RSP_READY.
- Strobes are registered outputs and never glitch. SLV_RE and SLV_WE are never both nonzero. At most one bit of either vector is set.

## Timing
- Reset values: CMD_READY=0 while OPB_RST is high and 1 in the first cycle after release. RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, OPB_ADDR=0, OPB_WDATA=0, SLV_RE=0, SLV_WE=0. State=IDLE.
- Accept in cycle A:
  - Strobe high in cycle A+1.
  - Write: RSP_VALID in A+2.
  - Read: data sampled at the end of cycle A+1+RD_LAT; RSP_VALID in A+2+RD_LAT.
- With RD_LAT=1: read issue-to-response = 3 cycles; write = 2 cycles.
- Error response: RSP_VALID in A+1.
- If RSP_READY is high in the first RESP cycle, RESP lasts one cycle; otherwise RSP_VALID holds until RSP_READY.
- Reset asserted mid-transaction: everything clears asynchronously to the reset values. The pending response is discarded, and no strobe is emitted after reset release.

## Test plan
- Write: accept {WR=1, ADDR=0x0000_0202, WDATA=0x2000_00FF} in cycle A.
  - SLV_WE=0x04 only in A+1, with OPB_ADDR=0x202 and OPB_WDATA=0x200000FF.
  - RSP_VALID in A+2 with RDATA=0, ERR=0.
- Read, RD_LAT=1: accept {WR=0, ADDR=0x0000_0302}; slave 3 model drives 0xA5A5_1234 in cycle A+2 only, and other slaves drive 0xFFFF_FFFF.
  - SLV_RE=0x08 in A+1.
  - RSP_RDATA=0xA5A51234 and RSP_VALID in A+3.
- Unmapped slave: ADDR=0x0000_0900 with NUM_SLAVES=8.
  - SLV_RE/SLV_WE stay 0.
  - RSP_VALID in A+1 with ERR=1, RDATA=0.
- Backpressure: hold RSP_READY=0 for 5 cycles after RSP_VALID while CMD_VALID stays high.
  - RSP fields are stable and CMD_READY=0 throughout.
  - The second command is accepted the cycle after RSP_READY=1.
- RD_LAT=3 build: slave drives data only in cycle A+4.
  - Correct word is captured; RSP_VALID in A+5.
- Reset: assert OPB_RST during WAIT of a read.
  - All outputs return to reset values immediately.
  - After release, no strobe and no RSP_VALID until a new command is accepted.
